// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared types and constants for the 2-bit-per-cycle serial
//                adder controller (state encoding, default operand width).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int C_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bit2_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bit2_adder
//  Description : 2-bit ripple-carry slice. Also exposes the carry between its
//                two bit positions, which is the carry into the operand MSB
//                when the slice handles the top two bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit2_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout,
    output logic       c_mid
);

    logic [1:0] w_low;
    logic [1:0] w_high;

    assign w_low  = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, cin};
    assign w_high = {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, w_low[1]};

    assign sum   = {w_high[0], w_low[0]};
    assign c_mid = w_low[1];
    assign cout  = w_high[1];

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Serial adder controller. Captures a, b and cin on an accepted
//                start, then adds two bits per cycle (LSB first) through one
//                bit2_adder slice, taking WIDTH/2 RUN cycles followed by a
//                one-cycle DONE pulse. WIDTH must be even and at least 4.
//                Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow
//                output ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              C_SLICES = WIDTH / 2;
    localparam int              C_CW     = $clog2(C_SLICES);
    localparam logic [C_CW-1:0] C_LAST   = C_CW'(C_SLICES - 1);
    localparam logic [C_CW-1:0] C_ONE    = C_CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [C_CW-1:0]  r_cnt;

    logic [1:0]       w_a_sl;
    logic [1:0]       w_b_sl;
    logic [1:0]       w_sl_sum;
    logic             w_sl_cout;
    logic             w_c_mid;

    // Current slice operands, addressed by the slice counter
    assign w_a_sl = r_a[{r_cnt, 1'b0} +: 2];
    assign w_b_sl = r_b[{r_cnt, 1'b0} +: 2];

    bit2_adder u_slice (
        .a     (w_a_sl),
        .b     (w_b_sl),
        .cin   (r_carry),
        .sum   (w_sl_sum),
        .cout  (w_sl_cout),
        .c_mid (w_c_mid)
    );

`ifndef SERIAL_ADD_OVF_EN
    // Mid-slice carry only feeds the overflow flag
    logic w_unused_c_mid;
    assign w_unused_c_mid = w_c_mid;
`endif

    // Control FSM with registered outputs; the datapath registers live here too
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Accept: capture operands, restart at slice 0
                        r_state <= RUN;
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        ovf     <= 1'b0;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here
                    sum[{r_cnt, 1'b0} +: 2] <= w_sl_sum;
                    r_carry                 <= w_sl_cout;
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cout    <= w_sl_cout;
`ifdef SERIAL_ADD_OVF_EN
                        ovf     <= w_c_mid ^ w_sl_cout;
`endif
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl: directed vector
//                table, randomized operands against an arithmetic model, and
//                hand-written sequences for ignored start, reset during RUN
//                and back-to-back operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 32;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_s;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf_s)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf_s = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Plain wide arithmetic: {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0]   full;
        logic         o;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; returns result and number of timing-profile errors
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int perr);
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        step();
        start = 1'b0; a = $urandom; b = $urandom; cin = 1'b1;
        perr = 0;
        for (int i = 1; i <= N; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) perr++;
            step();
        end
        if (done !== 1'b1 || busy !== 1'b0) perr++;
        rs = sum; rc = cout; ro = ovf_s;
        step();
        if (done !== 1'b0 || busy !== 1'b0) perr++;
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        int           perr;
        logic [W+1:0] m;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        int           cnt;

        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

        // Reset must act without any clock edge
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        check("reset_async_outs", {busy, done, cout, ovf_s, sum}, 64'd0);
        step();
        step();
        rst = 1'b0;

        // Directed table; first op starts on the first edge after reset release
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, rs, rc, ro, perr);
            check($sformatf("vec%0d_profile", i), 64'(perr), 64'd0);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].esum));
            check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].ecout));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].eovf));
`endif
            check($sformatf("vec%0d_hold", i), 64'({cout, sum}), 64'({vecs[i].ecout, vecs[i].esum}));
        end

        // Randomized operands against the model
        for (int i = 0; i < 16; i++) begin
            a1 = $urandom; b1 = $urandom;
            if (i == 0) begin a1 = 32'hAAAA_AAAA; b1 = 32'h5555_5555; end
            m = model(a1, b1, i[0]);
            run_op(a1, b1, i[0], rs, rc, ro, perr);
            check($sformatf("rnd%0d_profile", i), 64'(perr), 64'd0);
            check($sformatf("rnd%0d_result", i), 64'({rc, rs}), 64'(m[W:0]));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("rnd%0d_ovf", i), 64'(ro), 64'(m[W+1]));
`endif
        end

        // start reasserted in RUN cycle 5 must be ignored
        a1 = 32'h1234_5678; b1 = 32'h0F0F_F0F0;
        m = model(a1, b1, 1'b0);
        start = 1'b1; a = a1; b = b1; cin = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= N; c++) begin
            if (c == 5) begin start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111; cin = 1'b1; end
            if (c == 6) start = 1'b0;
            step();
        end
        check("ignore_done", 64'({busy, done}), 64'b01);
        check("ignore_result", 64'({cout, sum}), 64'(m[W:0]));
        step();

        // Reset during RUN cycle 8: outputs clear at once, no done, then recover
        start = 1'b1; a = 32'hCAFE_0001; b = 32'h0000_FFFF; cin = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        #3 rst = 1'b1;
        #1;
        check("rst_run_outs", {busy, done, cout, ovf_s, sum}, 64'd0);
        step();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1 || busy === 1'b1) cnt++;
            step();
        end
        check("rst_no_done", 64'(cnt), 64'd0);
        m = model(32'h0BAD_F00D, 32'h1357_9BDF, 1'b1);
        run_op(32'h0BAD_F00D, 32'h1357_9BDF, 1'b1, rs, rc, ro, perr);
        check("rst_recover_profile", 64'(perr), 64'd0);
        check("rst_recover_result", 64'({rc, rs}), 64'(m[W:0]));

        // Back-to-back: start held through the DONE cycle
        a1 = 32'h0000_1000; b1 = 32'h0000_0234;
        start = 1'b1; a = a1; b = b1; cin = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < N; c++) step();
        start = 1'b1; a = 32'h0000_0003; b = 32'h0000_0005; cin = 1'b0;
        step();
        check("b2b_first_done", 64'({busy, done}), 64'b01);
        check("b2b_first_sum", 64'(sum), 64'h0000_1234);
        step();
        start = 1'b0; a = '0; b = '0;
        check("b2b_no_gap", 64'({busy, done}), 64'b10);
        perr = 0;
        for (int c = 2; c <= N; c++) begin
            step();
            if (busy !== 1'b1 || done !== 1'b0) perr++;
        end
        step();
        check("b2b_busy_run", 64'(perr), 64'd0);
        check("b2b_second_done", 64'({busy, done}), 64'b01);
        check("b2b_second_result", 64'({cout, sum}), 64'h0_0000_0008);
        step();
        check("b2b_done_pulse_end", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; it must be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, sampled on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, sampled on the accepting edge.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, sampled on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while the block is in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH bits: the result.
REQ-011 SHALL have port cout, output, 1 bit: carry-out of the MSB.
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow; this port exists only when SERIAL_ADD_OVF_EN is defined.

Function
REQ-013 SHALL implement an FSM with the states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the last slice.
- DONE -> RUN on start=1.
- DONE -> IDLE on start=0.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it captures a, b and cin, and clears the slice counter.
REQ-015 SHALL ignore start while in RUN; operands, counter and outputs are unaffected.
REQ-016 SHALL process one 2-bit slice per RUN cycle, LSB first.
- Slice k uses operand bits [2k+1:2k] and the registered carry.
- It writes sum bits [2k+1:2k] and updates the carry register.
REQ-017 SHALL use N = WIDTH/2 RUN cycles.
- If start is sampled high in cycle 0, busy is high in cycles 1..N.
- done is high in cycle N+1 only. For WIDTH=32, done comes 17 cycles after acceptance.
REQ-018 SHALL use a slice counter of clog2(N) bits that wraps from N-1 to 0 on the RUN->DONE transition.
REQ-019 SHALL drive sum and cout with the final result from the DONE cycle onward, held until the next accepted start.
REQ-020 SHALL leave sum bits not yet written during RUN undefined to the consumer; only the DONE-cycle value is architectural.
REQ-021 SHALL, when start is high in the DONE cycle, accept it: done is high in that cycle and low in the next, and the new operation starts with no idle gap.
REQ-022 SHALL never assert busy and done in the same cycle.

Reset
REQ-023 SHALL, while rst=1, force the following immediately, independent of clk:
- state = IDLE
- counter = 0
- carry register = 0
- sum = 0, cout = 0
- busy = 0, done = 0
- ovf = 0 (when present)
REQ-024 SHALL, on reset during RUN, abandon the operation and produce no done pulse.
REQ-025 SHALL accept start on the first rising edge after rst is deasserted.

Configuration
REQ-026 SHALL, with SERIAL_ADD_OVF_EN defined, compute ovf = carry into MSB XOR carry out of MSB on the final slice, valid with sum and cleared on acceptance.
REQ-027 SHALL, without SERIAL_ADD_OVF_EN, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the following in the shared package serial_add_pkg:
- the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
- the default width constant
REQ-029 SHALL instantiate exactly one bit2_adder (2-bit ripple slice) as its only arithmetic sub-module; there shall be no other adder logic.

Verification
REQ-030 SHALL cover: a=32'h0000_0001, b=32'h0000_0001, cin=0, start pulse -> busy for 16 cycles; done in cycle 17; sum=32'h0000_0002, cout=0.
REQ-031 SHALL cover: a=32'hFFFF_FFFF, b=32'h0000_0000, cin=1 -> sum=32'h0000_0000, cout=1, ovf=0.
REQ-032 SHALL cover, with SERIAL_ADD_OVF_EN: a=32'h7FFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h8000_0000, cout=0, ovf=1.
REQ-033 SHALL cover: start reasserted with new operands in cycle 5 of RUN -> ignored; the result equals the first operation's sum.
REQ-034 SHALL cover: rst pulsed in cycle 8 of RUN -> all outputs 0 immediately; no done pulse; the next start completes normally.
REQ-035 SHALL cover: start held high through the DONE cycle with a=32'h0000_0003, b=32'h0000_0005 -> back-to-back operation; second done 17 cycles later; sum=32'h0000_0008.
